// File: rtl/mem_responder.sv
// Word-addressed backing memory for the cache mem_* port.
// Serves one request at a time after a fixed latency.
module mem_responder #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_AW     = 10,
  parameter int                    LATENCY    = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_DEAD
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_valid_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_adr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic                  mem_ready_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_err_o,
  output logic                  busy_o,
  output logic [15:0]           rd_cnt_o,
  output logic [15:0]           wr_cnt_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic                  r_oor;
  logic [MEM_AW-1:0]     r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [15:0]           r_rd_cnt;
  logic [15:0]           r_wr_cnt;

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<MEM_AW)-1];

  logic                  w_in_oor;
  logic                  w_enter;
  logic                  w_e_we;
  logic                  w_e_oor;
  logic [MEM_AW-1:0]     w_e_idx;
  logic [DATA_WIDTH-1:0] w_e_word;

  // Decode the transaction that enters RESP on this edge.
  // From IDLE (LATENCY of 1) it is still on the inputs.
  always_comb begin
    w_in_oor = (mem_adr_i >> MEM_AW) != '0;
    w_enter  = (r_state == S_IDLE && mem_valid_i && LATENCY == 1)
            || (r_state == S_BUSY && r_cnt == CW'(1));
    w_e_we   = (r_state == S_IDLE) ? mem_we_i : r_we;
    w_e_oor  = (r_state == S_IDLE) ? w_in_oor : r_oor;
    w_e_idx  = (r_state == S_IDLE) ? mem_adr_i[MEM_AW-1:0] : r_idx;
    w_e_word = w_e_oor ? ERR_DATA : r_mem[w_e_idx];
  end

  // Control FSM with registered handshake outputs and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_oor    <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_rdata  <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (mem_valid_i) begin
            r_we    <= mem_we_i;
            r_oor   <= w_in_oor;
            r_idx   <= mem_adr_i[MEM_AW-1:0];
            r_wdata <= mem_wdata_i;
            r_cnt   <= CW'(LATENCY - 1);
            r_busy  <= 1'b1;
            if (LATENCY == 1) r_state <= S_RESP;
            else              r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == CW'(1)) r_state <= S_RESP;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        S_RESP: begin
          r_busy <= 1'b0;
          if (r_we) begin
            if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
          end else begin
            if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
          end
          if (mem_valid_i) r_state <= S_DRAIN;
          else             r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (!mem_valid_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_enter) begin
        r_ready <= 1'b1;
        r_err   <= w_e_oor;
        if (!w_e_we) r_rdata <= w_e_word;
      end
    end
  end

  // Commit in-range writes at the end of the RESP cycle.
  always_ff @(posedge clk_i) begin
    if (r_state == S_RESP && r_we && !r_oor)
      r_mem[r_idx] <= r_wdata;
  end

  assign mem_ready_o = r_ready;
  assign mem_rdata_o = r_rdata;
  assign mem_err_o   = r_err;
  assign busy_o      = r_busy;
  assign rd_cnt_o    = r_rd_cnt;
  assign wr_cnt_o    = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// A LATENCY=4 and a LATENCY=1 instance share inputs.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] wdata = '0;

  logic        r4_ready, r4_err, r4_busy;
  logic [31:0] r4_rdata;
  logic [15:0] r4_rd, r4_wr;
  logic        r1_ready, r1_err, r1_busy;
  logic [31:0] r1_rdata;
  logic [15:0] r1_rd, r1_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_valid_i(valid), .mem_we_i(we),
    .mem_adr_i(adr), .mem_wdata_i(wdata),
    .mem_ready_o(r4_ready), .mem_rdata_o(r4_rdata),
    .mem_err_o(r4_err), .busy_o(r4_busy),
    .rd_cnt_o(r4_rd), .wr_cnt_o(r4_wr)
  );

  mem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_valid_i(valid), .mem_we_i(we),
    .mem_adr_i(adr), .mem_wdata_i(wdata),
    .mem_ready_o(r1_ready), .mem_rdata_o(r1_rdata),
    .mem_err_o(r1_err), .busy_o(r1_busy),
    .rd_cnt_o(r1_rd), .wr_cnt_o(r1_wr)
  );

  // Issue one request; n = edges from acceptance (E0 = 1) to ready seen.
  task automatic do_req(input bit sel, input logic w,
                        input logic [15:0] a, input logic [31:0] d,
                        input bit hold, output int n,
                        output logic [31:0] rd, output logic er);
    bit got;
    @(negedge clk);
    valid = 1'b1; we = w; adr = a; wdata = d;
    n = 0; got = 0; rd = 'x; er = 1'bx;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (sel ? r1_ready : r4_ready) begin
        got = 1;
        rd = sel ? r1_rdata : r4_rdata;
        er = sel ? r1_err : r4_err;
      end
    end
    if (!got) n = -1;
    if (!hold) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (r4_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", r4_ready); end
    checks++; if (r4_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", r4_rdata); end
    checks++; if (r4_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", r4_err); end
    checks++; if (r4_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", r4_busy); end
    checks++; if (r4_rd !== 16'h0) begin errors++; $display("FAIL rst_rdcnt got %h exp 0", r4_rd); end
    checks++; if (r4_wr !== 16'h0) begin errors++; $display("FAIL rst_wrcnt got %h exp 0", r4_wr); end
    checks++; if (r1_busy !== 1'b0 || r1_ready !== 1'b0) begin errors++; $display("FAIL rst_l1 got busy %b ready %b exp 0 0", r1_busy, r1_ready); end
  endtask

  task automatic test_write;
    int n; logic [31:0] rd; logic er;
    do_req(0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, n, rd, er);
    checks++; if (n != 4) begin errors++; $display("FAIL wr_latency got %0d exp 4", n); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", er); end
    @(posedge clk); #1;
    checks++; if (r4_wr !== 16'd1) begin errors++; $display("FAIL wr_cnt got %0d exp 1", r4_wr); end
    checks++; if (r4_ready !== 1'b0 || r4_busy !== 1'b0) begin errors++; $display("FAIL wr_after got ready %b busy %b exp 0 0", r4_ready, r4_busy); end
  endtask

  task automatic test_read;
    int n; logic [31:0] rd; logic er;
    do_req(0, 1'b0, 16'h0010, 32'h0, 0, n, rd, er);
    checks++; if (n != 4) begin errors++; $display("FAIL rd_latency got %0d exp 4", n); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", er); end
    repeat (2) @(posedge clk); #1;
    checks++; if (r4_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %h exp deadbeef", r4_rdata); end
    checks++; if (r4_rd !== 16'd1) begin errors++; $display("FAIL rd_cnt got %0d exp 1", r4_rd); end
  endtask

  task automatic test_drain;
    int n; logic [31:0] rd; logic er; int bad;
    do_req(0, 1'b0, 16'h0010, 32'h0, 1, n, rd, er);
    checks++; if (n != 4) begin errors++; $display("FAIL drain_first got %0d exp 4", n); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (r4_busy !== 1'b0 || r4_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL drain_hold got %0d busy/ready cycles exp 0", bad); end
    @(negedge clk); valid = 1'b0;
    do_req(0, 1'b0, 16'h0020, 32'h0, 0, n, rd, er);
    checks++; if (n != 4) begin errors++; $display("FAIL drain_second got %0d exp 4", n); end
    @(posedge clk); #1;
    checks++; if (r4_rd !== 16'd3) begin errors++; $display("FAIL drain_rdcnt got %0d exp 3", r4_rd); end
    checks++; if (r4_rdata !== rd) begin errors++; $display("FAIL drain_rdhold got %h exp %h", r4_rdata, rd); end
  endtask

  task automatic test_oor;
    int n; logic [31:0] rd; logic er;
    do_req(0, 1'b1, 16'h0000, 32'hA5A5A5A5, 0, n, rd, er);
    do_req(0, 1'b1, 16'h0400, 32'h12345678, 0, n, rd, er);
    checks++; if (n != 4) begin errors++; $display("FAIL oor_wr_latency got %0d exp 4", n); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", er); end
    do_req(0, 1'b0, 16'h0000, 32'h0, 0, n, rd, er);
    checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin errors++; $display("FAIL oor_alias got %h err %b exp a5a5a5a5 0", rd, er); end
    do_req(0, 1'b0, 16'h0400, 32'h0, 0, n, rd, er);
    checks++; if (rd !== 32'hDEADDEAD) begin errors++; $display("FAIL oor_rd_data got %h exp deaddead", rd); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b exp 1", er); end
    @(posedge clk); #1;
    checks++; if (r4_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %b exp 0", r4_err); end
    checks++; if (r4_wr !== 16'd3) begin errors++; $display("FAIL oor_wrcnt got %0d exp 3", r4_wr); end
  endtask

  task automatic test_reset_mid;
    int n; logic [31:0] rd; logic er; int seen;
    do_req(0, 1'b1, 16'h0030, 32'h00000055, 0, n, rd, er);
    @(negedge clk);
    valid = 1'b1; we = 1'b1; adr = 16'h0030; wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (r4_ready === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_ready got %0d pulses exp 0", seen); end
    checks++; if (r4_wr !== 16'd0) begin errors++; $display("FAIL rstmid_wrcnt got %0d exp 0", r4_wr); end
    checks++; if (r4_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", r4_busy); end
    do_req(0, 1'b0, 16'h0030, 32'h0, 0, n, rd, er);
    checks++; if (rd !== 32'h00000055) begin errors++; $display("FAIL rstmid_nocommit got %h exp 00000055", rd); end
    do_req(0, 1'b1, 16'h0030, 32'h11223344, 0, n, rd, er);
    do_req(0, 1'b0, 16'h0030, 32'h0, 0, n, rd, er);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL rstmid_rdback got %h exp 11223344", rd); end
  endtask

  task automatic test_back_to_back;
    int n; logic [31:0] rd; logic er;
    repeat (6) @(negedge clk);
    do_req(1, 1'b0, 16'h0010, 32'h0, 0, n, rd, er);
    checks++; if (n != 1) begin errors++; $display("FAIL l1_rd_latency got %0d exp 1", n); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL l1_rd_data got %h exp deadbeef", rd); end
    do_req(1, 1'b1, 16'h0010, 32'h0, 0, n, rd, er);
    checks++; if (n != 1) begin errors++; $display("FAIL l1_wr_latency got %0d exp 1", n); end
    do_req(1, 1'b0, 16'h0010, 32'h0, 0, n, rd, er);
    checks++; if (n != 1) begin errors++; $display("FAIL l1_rd2_latency got %0d exp 1", n); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL l1_rd2_data got %h exp 0", rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_drain();
    test_oor();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
